// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: operation codes, the
// multiply/divide sequencer states and the width legality check.
package alu_pkg;

    localparam logic [5:0] F_ADD   = 6'b000000;
    localparam logic [5:0] F_SUB   = 6'b000001;
    localparam logic [5:0] F_AND   = 6'b011000;
    localparam logic [5:0] F_OR    = 6'b011110;
    localparam logic [5:0] F_XOR   = 6'b010110;
    localparam logic [5:0] F_NOR   = 6'b010001;
    localparam logic [5:0] F_PASSB = 6'b011010;
    localparam logic [5:0] F_SLL   = 6'b100000;
    localparam logic [5:0] F_SRL   = 6'b100001;
    localparam logic [5:0] F_SRA   = 6'b100011;
    localparam logic [5:0] F_EQ    = 6'b110011;
    localparam logic [5:0] F_NE    = 6'b110001;
    localparam logic [5:0] F_LT    = 6'b110101;
    localparam logic [5:0] F_LEZ   = 6'b111101;
    localparam logic [5:0] F_LTZ   = 6'b111011;
    localparam logic [5:0] F_GTZ   = 6'b111111;
    localparam logic [5:0] F_MFHI  = 6'b001010;
    localparam logic [5:0] F_MFLO  = 6'b001011;
    localparam logic [5:0] F_MUL   = 6'b001000;
    localparam logic [5:0] F_DIV   = 6'b001001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } state_t;

    // A legal configuration is at least 8 bits wide, even, and the shift
    // amount field must address exactly every bit position.
    function automatic bit width_ok(input int w, input int s);
        return (w >= 8) && ((w % 2) == 0) && ((1 << s) == w);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative multiply / divide engine: radix-2 shift-add multiply and
// restoring divide on operand magnitudes, followed by one sign-fix cycle.
// HI/LO are only updated on the FIX->IDLE edge.
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,      // 0 = multiply, 1 = divide
    input  logic             sign,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] res     // final LO value, valid while done
);

    localparam logic [SHAMT_W-1:0] LAST = SHAMT_W'(WIDTH - 1);

    state_t               state_q, state_d;
    logic [SHAMT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]     acc_q, acc_d;     // product high half / partial remainder
    logic [WIDTH-1:0]     low_q, low_d;     // multiplier & product low half / dividend & quotient
    logic [WIDTH-1:0]     mb_q;             // multiplicand or divisor magnitude
    logic [WIDTH-1:0]     a_q;
    logic                 op_q, ngq_q, ngr_q, dz_q;
    logic [WIDTH-1:0]     hi_q, lo_q;

    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_sh;
    logic [WIDTH:0]       div_tr;
    logic [2*WIDTH-1:0]   prod, prod_fix;
    logic [WIDTH-1:0]     fix_hi, fix_lo;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic s);
        return (s && x[WIDTH-1]) ? -x : x;
    endfunction

    // Sequencer state register; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: WIDTH iteration cycles, then a single FIX cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = op ? DIV : MUL;
                    cnt_d   = '0;
                end
            end
            MUL, DIV: begin
                cnt_d = cnt_q + SHAMT_W'(1);
                if (cnt_q == LAST) begin
                    state_d = FIX;
                end
            end
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // One radix-2 step of either algorithm on the partial registers.
    always_comb begin
        mul_sum = {1'b0, acc_q} + (low_q[0] ? {1'b0, mb_q} : '0);
        div_sh  = {acc_q, low_q[WIDTH-1]};
        div_tr  = div_sh - {1'b0, mb_q};
        if (state_q == MUL) begin
            acc_d = mul_sum[WIDTH:1];
            low_d = {mul_sum[0], low_q[WIDTH-1:1]};
        end else if (!div_tr[WIDTH]) begin
            acc_d = div_tr[WIDTH-1:0];
            low_d = {low_q[WIDTH-2:0], 1'b1};
        end else begin
            acc_d = div_sh[WIDTH-1:0];
            low_d = {low_q[WIDTH-2:0], 1'b0};
        end
    end

    // Partial registers: load magnitudes and sign info at start, then iterate.
    always_ff @(posedge clk) begin
        if (start && state_q == IDLE) begin
            acc_q <= '0;
            low_q <= magnitude(a, sign);
            mb_q  <= magnitude(b, sign);
            a_q   <= a;
            op_q  <= op;
            ngq_q <= sign & (a[WIDTH-1] ^ b[WIDTH-1]);
            ngr_q <= sign & a[WIDTH-1];
            dz_q  <= (b == '0);
        end else if (state_q == MUL || state_q == DIV) begin
            acc_q <= acc_d;
            low_q <= low_d;
        end
    end

    // FIX step: restore signs and apply the divide-by-zero result.
    always_comb begin
        prod     = {acc_q, low_q};
        prod_fix = ngq_q ? -prod : prod;
        if (!op_q) begin
            fix_hi = prod_fix[2*WIDTH-1:WIDTH];
            fix_lo = prod_fix[WIDTH-1:0];
        end else if (dz_q) begin
            fix_hi = a_q;
            fix_lo = '1;
        end else begin
            fix_hi = ngr_q ? -acc_q : acc_q;
            fix_lo = ngq_q ? -low_q : low_q;
        end
    end

    // HI/LO architectural registers, written only when the result is final.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (state_q == FIX) begin
            hi_q <= fix_hi;
            lo_q <= fix_lo;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == FIX);
    assign hi   = hi_q;
    assign lo   = lo_q;
    assign res  = fix_lo;

endmodule

// File: rtl/alu_muldiv.sv
// Execute-stage ALU: single-cycle ops with registered result and flags,
// plus an iterative multiply/divide unit behind a valid/ready handshake.
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       funct,
    input  logic             sign,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             out_valid,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             overflow,
    output logic             negative,
    output logic             busy
);

    if (!width_ok(WIDTH, SHAMT_W)) begin : g_width_check
        $fatal(1, "alu_muldiv: WIDTH must be >= 8, even, and equal 2**SHAMT_W");
    end

    logic signed [WIDTH-1:0] in1_s, in2_s;
    logic [WIDTH:0]          sum, diff;
    logic [SHAMT_W-1:0]      shamt;
    logic [WIDTH-1:0]        res_d;
    logic                    zero_d, ovf_d, neg_d, is_md, md_op;
    logic                    accept, md_busy, md_done;
    logic [WIDTH-1:0]        md_hi, md_lo, md_res;

    logic [WIDTH-1:0]        out_q;
    logic                    out_valid_q, zero_q, ovf_q, neg_q;

    assign in1_s  = in1;
    assign in2_s  = in2;
    assign sum    = {1'b0, in1} + {1'b0, in2};
    assign diff   = {1'b0, in1} - {1'b0, in2};
    assign shamt  = in1[SHAMT_W-1:0];
    assign accept = in_valid & ~md_busy;

    function automatic logic [WIDTH-1:0] bit2word(input logic b);
        return {{(WIDTH-1){1'b0}}, b};
    endfunction

    // Operation decode: result and flags for the op presented this cycle.
    always_comb begin
        res_d  = '0;
        ovf_d  = 1'b0;
        zero_d = (in1 == in2);
        neg_d  = sign & diff[WIDTH-1];
        is_md  = 1'b0;
        md_op  = 1'b0;
        case (funct)
            F_ADD: begin
                res_d = sum[WIDTH-1:0];
                ovf_d = sign ? ((in1[WIDTH-1] == in2[WIDTH-1]) && (sum[WIDTH-1] != in1[WIDTH-1]))
                             : sum[WIDTH];
            end
            F_SUB: begin
                res_d = diff[WIDTH-1:0];
                ovf_d = sign ? ((in1[WIDTH-1] != in2[WIDTH-1]) && (diff[WIDTH-1] != in1[WIDTH-1]))
                             : diff[WIDTH];
            end
            F_AND:   res_d = in1 & in2;
            F_OR:    res_d = in1 | in2;
            F_XOR:   res_d = in1 ^ in2;
            F_NOR:   res_d = ~(in1 | in2);
            F_PASSB: res_d = in2;
            F_SLL:   res_d = in2 << shamt;
            F_SRL:   res_d = in2 >> shamt;
            F_SRA:   res_d = in2_s >>> shamt;
            F_EQ:    res_d = bit2word(in1 == in2);
            F_NE:    res_d = bit2word(in1 != in2);
            F_LT:    res_d = bit2word(sign ? (in1_s < in2_s) : diff[WIDTH]);
            F_LEZ:   res_d = bit2word(sign && (in1_s <= 0));
            F_LTZ:   res_d = bit2word(sign && in1[WIDTH-1]);
            F_GTZ:   res_d = bit2word(sign ? (in1_s > 0) : 1'b1);
            F_MFHI:  res_d = md_hi;
            F_MFLO:  res_d = md_lo;
            F_MUL:   is_md = 1'b1;
            F_DIV: begin
                is_md = 1'b1;
                md_op = 1'b1;
            end
            default: begin
                zero_d = 1'b0;
                neg_d  = 1'b0;
            end
        endcase
    end

    muldiv_iter #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_muldiv (
        .clk   (clk),
        .reset (reset),
        .start (accept & is_md),
        .op    (md_op),
        .sign  (sign),
        .a     (in1),
        .b     (in2),
        .busy  (md_busy),
        .done  (md_done),
        .hi    (md_hi),
        .lo    (md_lo),
        .res   (md_res)
    );

    // Result/flag registers: single-cycle ops land one cycle after acceptance,
    // multiply/divide results land on the sequencer's FIX->IDLE edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            neg_q       <= 1'b0;
        end else begin
            out_valid_q <= (accept & ~is_md) | md_done;
            if (accept) begin
                zero_q <= zero_d;
                ovf_q  <= ovf_d;
                neg_q  <= neg_d;
            end
            if (accept && !is_md) begin
                out_q <= res_d;
            end else if (md_done) begin
                out_q <= md_res;
            end
        end
    end

    assign in_ready  = ~md_busy;
    assign busy      = md_busy;
    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign zero      = zero_q;
    assign overflow  = ovf_q;
    assign negative  = neg_q;

endmodule
